// File: rtl/uart_frame_sequencer.sv
// Collects a fixed-length frame of UART bytes, then retransmits the frame followed by its
// modulo-2^N checksum, with an inter-byte timeout and a sticky overrun flag.
module uart_frame_sequencer #(
   parameter int N_DATA_BITS    = 8,
   parameter int N_WORDS        = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_DATA_BITS-1:0] i_rx_data,
   input  logic                   i_rx_valid,
   input  logic                   i_tx_ready,
   output logic [N_DATA_BITS-1:0] o_tx_data,
   output logic                   o_tx_valid,
   output logic [N_DATA_BITS-1:0] o_sum,
   output logic                   o_sum_valid,
   output logic                   o_busy,
   output logic                   o_timeout_err,
   output logic                   o_overrun
);

   localparam int CW = $clog2(N_WORDS + 1);
   localparam int IW = $clog2(N_WORDS);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(N_WORDS);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N_WORDS - 1);
   localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, COLLECT, SEND_DATA, SEND_SUM} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [N_DATA_BITS-1:0] run_sum_q, run_sum_d;
   logic [TW-1:0]          idle_q, idle_d;
   logic [N_DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic [N_DATA_BITS-1:0] sum_q, sum_d;
   logic                   sum_valid_q, sum_valid_d;
   logic                   busy_q, busy_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   overrun_q, overrun_d;

   logic [N_DATA_BITS-1:0] frame_buf [N_WORDS];
   logic                   buf_we;
   logic [IW-1:0]          buf_waddr;
   logic [N_DATA_BITS-1:0] next_sum;
   logic [IW-1:0]          idx_next;
   logic                   transfer;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      idx_d         = idx_q;
      run_sum_d     = run_sum_q;
      idle_d        = idle_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      sum_d         = sum_q;
      sum_valid_d   = 1'b0;
      timeout_err_d = 1'b0;
      overrun_d     = overrun_q;
      buf_we        = 1'b0;
      buf_waddr     = count_q[IW-1:0];
      next_sum      = run_sum_q + i_rx_data;
      idx_next      = idx_q + IW'(1);
      transfer      = tx_valid_q & i_tx_ready;

      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               buf_we    = 1'b1;
               buf_waddr = '0;
               run_sum_d = i_rx_data;
               count_d   = CW'(1);
               idle_d    = '0;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            // The abort wins over a byte arriving in the same cycle; that byte counts as dropped.
            if (idle_q == IDLE_MAX) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
               count_d       = '0;
               run_sum_d     = '0;
               idle_d        = '0;
               if (i_rx_valid) overrun_d = 1'b1;
            end else if (i_rx_valid) begin
               buf_we    = 1'b1;
               run_sum_d = next_sum;
               count_d   = count_q + CW'(1);
               idle_d    = '0;
               if (count_q + CW'(1) == LAST_COUNT) begin
                  state_d     = SEND_DATA;
                  sum_d       = next_sum;
                  sum_valid_d = 1'b1;
                  tx_valid_d  = 1'b1;
                  tx_data_d   = frame_buf[0];
                  idx_d       = '0;
               end
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         SEND_DATA: begin
            if (i_rx_valid) overrun_d = 1'b1;
            if (transfer) begin
               if (idx_q == LAST_IDX) begin
                  state_d   = SEND_SUM;
                  tx_data_d = sum_q;
               end else begin
                  idx_d     = idx_next;
                  tx_data_d = frame_buf[idx_next];
               end
            end
         end
         SEND_SUM: begin
            if (i_rx_valid) overrun_d = 1'b1;
            if (transfer) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
               count_d    = '0;
               idx_d      = '0;
               run_sum_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         idx_q         <= '0;
         run_sum_q     <= '0;
         idle_q        <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         sum_q         <= '0;
         sum_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         idx_q         <= idx_d;
         run_sum_q     <= run_sum_d;
         idle_q        <= idle_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         sum_q         <= sum_d;
         sum_valid_q   <= sum_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   // Frame storage carries no reset; stale contents are never read before being rewritten.
   always_ff @(posedge i_clk) begin
      if (buf_we) frame_buf[buf_waddr] <= i_rx_data;
   end

   assign o_tx_data     = tx_data_q;
   assign o_tx_valid    = tx_valid_q;
   assign o_sum         = sum_q;
   assign o_sum_valid   = sum_valid_q;
   assign o_busy        = busy_q;
   assign o_timeout_err = timeout_err_q;
   assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench for uart_frame_sequencer: directed frames push expected TX bytes and sums,
// a negedge monitor pops and compares them as the DUT delivers.
module tb_uart_frame_sequencer;

   localparam int TIMEOUT = 40;

   logic       clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       i_tx_ready;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic [7:0] o_sum;
   logic       o_sum_valid;
   logic       o_busy;
   logic       o_timeout_err;
   logic       o_overrun;

   int checks = 0;
   int fails  = 0;
   int tx_count = 0;
   int sum_pulses = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   logic [7:0] exp_tx_q [$];
   logic [7:0] exp_sum_q [$];
   logic [7:0] frame_bytes [16];

   uart_frame_sequencer #(
      .N_DATA_BITS(8), .N_WORDS(16), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
      .o_sum(o_sum), .o_sum_valid(o_sum_valid), .o_busy(o_busy),
      .o_timeout_err(o_timeout_err), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic valid);
      i_rx_data  = data;
      i_rx_valid = valid;
      stepCycle();
   endtask

   task automatic sendFrame(input logic [7:0] exp_sum);
      for (int i = 0; i < 16; i++) exp_tx_q.push_back(frame_bytes[i]);
      exp_tx_q.push_back(exp_sum);
      exp_sum_q.push_back(exp_sum);
      for (int i = 0; i < 16; i++) applyStimulus(frame_bytes[i], 1'b1);
      i_rx_valid = 1'b0;
   endtask

   task automatic fillRamp();
      for (int i = 0; i < 16; i++) frame_bytes[i] = 8'(i + 1);
   endtask

   task automatic fillConst(input logic [7:0] v);
      for (int i = 0; i < 16; i++) frame_bytes[i] = v;
   endtask

   // hold=1 stalls the transmitter 3 cycles at byte 5 and 3 cycles on the sum byte
   task automatic waitDrain(input string name, input bit hold, input int budget);
      int  base = tx_count;
      int  h5 = 0;
      int  hs = 0;
      bit  done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (exp_tx_q.size() == 0 && exp_sum_q.size() == 0 && !o_busy) begin
            done = 1'b1;
            break;
         end
         if (hold && (tx_count - base) == 5 && h5 < 3) begin
            i_tx_ready = 1'b0;
            h5++;
         end else if (hold && (tx_count - base) == 16 && hs < 3) begin
            i_tx_ready = 1'b0;
            hs++;
         end else begin
            i_tx_ready = 1'b1;
         end
         stepCycle();
      end
      i_tx_ready = 1'b1;
      checkOutput(name, 32'(done), 32'd1);
   endtask

   task automatic waitTx(input string name, input int n, input int budget);
      int base = tx_count;
      bit done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if ((tx_count - base) >= n) begin
            done = 1'b1;
            break;
         end
         stepCycle();
      end
      checkOutput(name, 32'(done), 32'd1);
   endtask

   // Monitor: pops the scoreboard on every transfer and every sum pulse, and checks hold-stability.
   always @(negedge clk) begin
      if (i_reset) begin
         if (prev_stall) begin
            checkOutput("tx_hold_valid", 32'(o_tx_valid), 32'd1);
            checkOutput("tx_hold_data", 32'(o_tx_data), 32'(prev_data));
         end
         if (o_tx_valid && i_tx_ready) begin
            checks++;
            if (exp_tx_q.size() == 0) begin
               fails++;
               $display("[TB] FAIL tx_extra: got %0h, expected no byte", o_tx_data);
            end else begin
               checks--;
               checkOutput("tx_byte", 32'(o_tx_data), 32'(exp_tx_q.pop_front()));
            end
            tx_count++;
         end
         if (o_sum_valid) begin
            checks++;
            if (exp_sum_q.size() == 0) begin
               fails++;
               $display("[TB] FAIL sum_extra: got %0h, expected no pulse", o_sum);
            end else begin
               checks--;
               checkOutput("sum_value", 32'(o_sum), 32'(exp_sum_q.pop_front()));
            end
            sum_pulses++;
         end
      end
      prev_stall = o_tx_valid && !i_tx_ready && i_reset;
      prev_data  = o_tx_data;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  base;
      bit  seen;
      i_reset    = 1'b0;
      i_rx_data  = '0;
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_tx_valid", 32'(o_tx_valid), 32'd0);
      checkOutput("rst_tx_data", 32'(o_tx_data), 32'd0);
      checkOutput("rst_sum", 32'(o_sum), 32'd0);
      checkOutput("rst_sum_valid", 32'(o_sum_valid), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_timeout", 32'(o_timeout_err), 32'd0);
      checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
      stepCycle();
      i_reset = 1'b1;
      stepCycle();

      // Ramp frame, transmitter always ready
      fillRamp();
      base = sum_pulses;
      sendFrame(8'h88);
      waitDrain("drain_ramp", 1'b0, 100);
      checkOutput("ramp_sum", 32'(o_sum), 32'h88);
      checkOutput("ramp_pulses", 32'(sum_pulses - base), 32'd1);
      checkOutput("ramp_idle_valid", 32'(o_tx_valid), 32'd0);

      // All-ones frame wraps the checksum
      fillConst(8'hFF);
      base = sum_pulses;
      sendFrame(8'hF0);
      waitDrain("drain_ff", 1'b0, 100);
      checkOutput("ff_sum", 32'(o_sum), 32'hF0);
      checkOutput("ff_pulses", 32'(sum_pulses - base), 32'd1);

      // Ramp frame with transmitter back-pressure
      fillRamp();
      base = sum_pulses;
      sendFrame(8'h88);
      waitDrain("drain_hold", 1'b1, 100);
      checkOutput("hold_sum", 32'(o_sum), 32'h88);
      checkOutput("hold_busy", 32'(o_busy), 32'd0);

      // Partial frame then silence
      base = sum_pulses;
      for (int i = 0; i < 5; i++) applyStimulus(8'(8'h11 + i), 1'b1);
      i_rx_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT + 10; c++) begin
         @(negedge clk);
         if (o_timeout_err) begin
            seen = 1'b1;
            break;
         end
         stepCycle();
      end
      checkOutput("timeout_seen", 32'(seen), 32'd1);
      checkOutput("timeout_busy", 32'(o_busy), 32'd0);
      checkOutput("timeout_sum", 32'(o_sum), 32'h88);
      stepCycle();
      @(negedge clk);
      checkOutput("timeout_one_pulse", 32'(o_timeout_err), 32'd0);
      checkOutput("timeout_no_sum_pulse", 32'(sum_pulses - base), 32'd0);
      stepCycle();
      fillConst(8'h02);
      sendFrame(8'h20);
      waitDrain("drain_twos", 1'b0, 100);
      checkOutput("twos_sum", 32'(o_sum), 32'h20);

      // Stray byte during SEND_DATA
      fillRamp();
      sendFrame(8'h88);
      waitTx("wait_overrun_point", 3, 50);
      applyStimulus(8'h55, 1'b1);
      i_rx_valid = 1'b0;
      @(negedge clk);
      checkOutput("overrun_set", 32'(o_overrun), 32'd1);
      stepCycle();
      waitDrain("drain_overrun", 1'b0, 100);
      checkOutput("overrun_sticky", 32'(o_overrun), 32'd1);
      checkOutput("overrun_sum", 32'(o_sum), 32'h88);

      // Reset in the middle of SEND_DATA
      fillRamp();
      sendFrame(8'h88);
      waitTx("wait_reset_point", 7, 50);
      i_reset    = 1'b0;
      i_tx_ready = 1'b0;
      stepCycle();
      @(negedge clk);
      checkOutput("midrst_tx_valid", 32'(o_tx_valid), 32'd0);
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_overrun", 32'(o_overrun), 32'd0);
      checkOutput("midrst_sum", 32'(o_sum), 32'd0);
      exp_tx_q.delete();
      exp_sum_q.delete();
      stepCycle();
      i_reset    = 1'b1;
      i_tx_ready = 1'b1;
      stepCycle();
      base = sum_pulses;
      sendFrame(8'h88);
      waitDrain("drain_after_reset", 1'b0, 100);
      checkOutput("after_reset_sum", 32'(o_sum), 32'h88);
      checkOutput("after_reset_pulses", 32'(sum_pulses - base), 32'd1);

      repeat (3) stepCycle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 Parameter N_DATA_BITS, default 8, is the byte width of the received, stored and transmitted data.
REQ-002 Parameter N_WORDS, default 16, is the number of bytes per frame; legal range 2..256.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, is the maximum idle gap in i_clk cycles allowed between bytes inside a frame.
REQ-004 i_clk  input  1  single clock; all logic is on its rising edge.
REQ-005 i_reset  input  1  synchronous reset, active-low, sampled on rising i_clk.
REQ-006 i_rx_data  input  N_DATA_BITS  received byte from the UART receiver.
REQ-007 i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-008 i_tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-009 o_tx_data  output  N_DATA_BITS  byte offered to the transmitter.
REQ-010 o_tx_valid  output  1  o_tx_data is valid.
REQ-011 o_sum  output  N_DATA_BITS  checksum of the last completed frame, for display.
REQ-012 o_sum_valid  output  1  one-cycle pulse when o_sum updates.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_timeout_err  output  1  one-cycle pulse on a frame abort.
REQ-015 o_overrun  output  1  sticky flag: a byte was dropped.

Function
REQ-016 The FSM shall have exactly four states: IDLE, COLLECT, SEND_DATA, SEND_SUM.
REQ-017 In IDLE, an i_rx_valid shall have these effects:
- write the byte to buffer[0];
- set the running sum to that byte and the byte count to 1;
- enter COLLECT.
REQ-018 In COLLECT, each i_rx_valid shall have these effects:
- write the byte to buffer[count];
- add it to the running sum modulo 2^N_DATA_BITS, carry discarded;
- increment count.
REQ-019 When the byte making count equal N_WORDS is accepted at cycle t, the block shall, on the edge ending cycle t:
- enter SEND_DATA;
- load o_sum with the final sum;
- pulse o_sum_valid so it is high during cycle t+1 only;
- present o_tx_valid=1 with o_tx_data=buffer[0] from cycle t+1.
REQ-020 In COLLECT, an idle-cycle counter shall clear on every i_rx_valid and increment on every other cycle.
REQ-021 When TIMEOUT_CYCLES consecutive cycles pass with no byte, the block shall:
- return to IDLE;
- pulse o_timeout_err for one cycle;
- leave o_sum unchanged;
- discard the partial frame.
REQ-022 In SEND_DATA, o_tx_valid shall be 1 and o_tx_data shall be buffer[idx], with idx starting at 0.
REQ-023 A transfer shall occur on a cycle where o_tx_valid and i_tx_ready are both 1; idx shall advance only on a transfer.
REQ-024 After the transfer of buffer[N_WORDS-1], the block shall enter SEND_SUM with no bubble cycle.
REQ-025 In SEND_SUM, o_tx_data shall be the frame sum and o_tx_valid shall be 1; on its transfer the block shall return to IDLE and o_tx_valid shall be 0 the next cycle.
REQ-026 Once o_tx_valid is asserted, it and o_tx_data shall stay stable until the transfer; no retraction and no duplicate byte.
REQ-027 An i_rx_valid in SEND_DATA or SEND_SUM shall be dropped and shall set o_overrun, which stays high until reset.
REQ-028 An i_rx_valid in the same cycle that SEND_SUM completes shall also be dropped, setting o_overrun; a frame starts only from IDLE.
REQ-029 An i_rx_valid in the same cycle that a timeout fires shall be dropped, with the abort taking priority.
REQ-030 o_busy shall be a registered decode of state != IDLE.

Reset
REQ-031 While i_reset=0 at a rising edge, the block shall enter IDLE and clear count, idx, sum and the idle counter.
REQ-032 The same reset shall clear every output to 0: o_sum, o_sum_valid, o_tx_valid, o_tx_data, o_busy, o_timeout_err and o_overrun.
REQ-033 Buffer contents need not be cleared by reset.
REQ-034 A reset asserted mid-frame or mid-send shall abandon the frame immediately, with o_tx_valid=0 on the following cycle.

Verification
REQ-035 Send bytes 0x01..0x10 back-to-back with i_tx_ready=1 -> TX stream 0x01..0x10 then 0x88; o_sum=0x88 with one o_sum_valid pulse.
REQ-036 Send 16 x 0xFF -> sum byte 0xF0 (wrap-around); o_sum=0xF0.
REQ-037 Run the 0x01..0x10 frame with i_tx_ready low for 3 cycles at idx 5 and during SEND_SUM -> o_tx_data held stable; all 17 bytes delivered once, in order.
REQ-038 Send 5 bytes then stay silent for TIMEOUT_CYCLES -> one o_timeout_err pulse, o_busy=0, o_sum unchanged; a following frame of 16 x 0x02 gives sum 0x20.
REQ-039 Inject an i_rx_valid of 0x55 during SEND_DATA -> o_overrun=1 and stays high; TX stream unaltered.
REQ-040 Assert i_reset=0 at idx 7 of SEND_DATA -> o_tx_valid=0, o_busy=0, o_overrun=0 on the next cycle; the next frame behaves as in REQ-035.
